// File: rtl/fft_stage_sequencer.sv
// Stage/address sequencer for an in-place radix-2 FFT on a two-bank ping-pong RAM.
// Issues butterfly read pairs and twiddle indices, and delays them into write pairs.
module fft_stage_sequencer #(
    parameter int  N        = 32,
    parameter int  PIPE_LAT = 3,
    localparam int L        = $clog2(N),
    localparam int KW       = L - 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          bank_select_o,
    output logic [L-1:0]  rd_address1_o,
    output logic [L-1:0]  rd_address2_o,
    output logic          rd_valid_o,
    output logic [KW-1:0] tw_addr_o,
    output logic [L-1:0]  wr_address1_o,
    output logic [L-1:0]  wr_address2_o,
    output logic          wr_en_o,
    output logic [L-1:0]  stage_o,
    output logic          result_bank_o
);

    localparam int            DW     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N / 2 - 1);
    localparam logic [L-1:0]  S_LAST = L'(L - 1);
    localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_SWAP,
        S_DONE
    } state_e;

    function automatic logic [L-1:0] span_mask(input logic [L-1:0] s);
        return (L'(1) << s) - L'(1);
    endfunction

    // Top index = k with a zero inserted at bit s (group bits move up, pos bits stay).
    function automatic logic [L-1:0] top_addr(input logic [KW-1:0] k, input logic [L-1:0] s);
        logic [L-1:0] kk;
        kk = L'(k);
        return ((kk >> s) << (s + L'(1))) | (kk & span_mask(s));
    endfunction

    function automatic logic [KW-1:0] twiddle(input logic [KW-1:0] k, input logic [L-1:0] s);
        logic [L-1:0] pos;
        pos = L'(k) & span_mask(s);
        return KW'(pos << (S_LAST - s));
    endfunction

    state_e        state_q;
    logic [KW-1:0] k_q;
    logic [L-1:0]  stage_q;
    logic [DW-1:0] drain_q;
    logic          busy_q;
    logic          done_q;
    logic          bank_q;
    logic          result_bank_q;
    logic          rd_valid_q;
    logic [L-1:0]  rd1_q;
    logic [L-1:0]  rd2_q;
    logic [KW-1:0] tw_q;

    logic [KW-1:0] k_d;
    logic [L-1:0]  stage_d;
    logic [L-1:0]  rd1_d;
    logic [L-1:0]  rd2_d;
    logic [KW-1:0] tw_d;

    logic          dl_v_q  [PIPE_LAT];
    logic [L-1:0]  dl_a1_q [PIPE_LAT];
    logic [L-1:0]  dl_a2_q [PIPE_LAT];

    // Address of the butterfly that will be issued in the cycle after this edge.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        k_d     = k_q + KW'(1);
        stage_d = stage_q;
        if (state_q == S_IDLE) begin
            k_d     = '0;
            stage_d = '0;
        end else if (state_q == S_SWAP) begin
            k_d     = '0;
            stage_d = stage_q + L'(1);
        end
        rd1_d = top_addr(k_d, stage_d);
        rd2_d = rd1_d | (L'(1) << stage_d);
        tw_d  = twiddle(k_d, stage_d);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            k_q           <= '0;
            stage_q       <= '0;
            drain_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            bank_q        <= 1'b0;
            result_bank_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd1_q         <= '0;
            rd2_q         <= '0;
            tw_q          <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q    <= S_READ;
                        stage_q    <= '0;
                        k_q        <= '0;
                        bank_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        rd_valid_q <= 1'b1;
                        rd1_q      <= rd1_d;
                        rd2_q      <= rd2_d;
                        tw_q       <= tw_d;
                    end
                end
                S_READ: begin
                    if (k_q == K_LAST) begin
                        state_q    <= S_DRAIN;
                        drain_q    <= '0;
                        rd_valid_q <= 1'b0;
                        rd1_q      <= '0;
                        rd2_q      <= '0;
                        tw_q       <= '0;
                    end else begin
                        k_q   <= k_d;
                        rd1_q <= rd1_d;
                        rd2_q <= rd2_d;
                        tw_q  <= tw_d;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == D_LAST) begin
                        state_q <= S_SWAP;
                    end else begin
                        drain_q <= drain_q + DW'(1);
                    end
                end
                S_SWAP: begin
                    bank_q <= ~bank_q;
                    if (stage_q == S_LAST) begin
                        state_q       <= S_DONE;
                        busy_q        <= 1'b0;
                        done_q        <= 1'b1;
                        result_bank_q <= stage_q[0];
                    end else begin
                        state_q    <= S_READ;
                        stage_q    <= stage_d;
                        k_q        <= '0;
                        rd_valid_q <= 1'b1;
                        rd1_q      <= rd1_d;
                        rd2_q      <= rd2_d;
                        tw_q       <= tw_d;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: the delay line is reset so an aborted run can never emit a stray write.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_v_q[i]  <= 1'b0;
                dl_a1_q[i] <= '0;
                dl_a2_q[i] <= '0;
            end
        end else begin
            dl_v_q[0]  <= rd_valid_q;
            dl_a1_q[0] <= rd1_q;
            dl_a2_q[0] <= rd2_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_v_q[i]  <= dl_v_q[i-1];
                dl_a1_q[i] <= dl_a1_q[i-1];
                dl_a2_q[i] <= dl_a2_q[i-1];
            end
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign bank_select_o = bank_q;
    assign rd_address1_o = rd1_q;
    assign rd_address2_o = rd2_q;
    assign rd_valid_o    = rd_valid_q;
    assign tw_addr_o     = tw_q;
    assign wr_address1_o = dl_a1_q[PIPE_LAT-1];
    assign wr_address2_o = dl_a2_q[PIPE_LAT-1];
    assign wr_en_o       = dl_v_q[PIPE_LAT-1];
    assign stage_o       = stage_q;
    assign result_bank_o = result_bank_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: cycle-by-cycle comparison against a transform-level
// model, a table of hand-computed butterfly vectors, and reset/start corner cases.
module tb_fft_stage_sequencer;

    localparam int N         = 32;
    localparam int PIPE_LAT  = 3;
    localparam int L         = 5;
    localparam int STAGE_LEN = N / 2 + PIPE_LAT + 1;
    localparam int TOTAL     = L * STAGE_LEN;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         busy, done, bank_select, rd_valid, wr_en, result_bank;
    logic [L-1:0] rd_address1, rd_address2, wr_address1, wr_address2, stage;
    logic [L-2:0] tw_addr;

    always #5 clk = ~clk;

    fft_stage_sequencer #(.N(N), .PIPE_LAT(PIPE_LAT)) dut (
        .clk_i         (clk),
        .reset_i       (rst),
        .start_i       (start),
        .busy_o        (busy),
        .done_o        (done),
        .bank_select_o (bank_select),
        .rd_address1_o (rd_address1),
        .rd_address2_o (rd_address2),
        .rd_valid_o    (rd_valid),
        .tw_addr_o     (tw_addr),
        .wr_address1_o (wr_address1),
        .wr_address2_o (wr_address2),
        .wr_en_o       (wr_en),
        .stage_o       (stage),
        .result_bank_o (result_bank)
    );

    typedef struct packed {
        logic         busy;
        logic         done;
        logic         bank;
        logic [L-1:0] rd1;
        logic [L-1:0] rd2;
        logic         rdv;
        logic [L-2:0] tw;
        logic [L-1:0] wr1;
        logic [L-1:0] wr2;
        logic         wren;
        logic [L-1:0] stage;
        logic         rb;
    } out_t;

    typedef struct packed {
        logic         v;
        logic [L-1:0] a1;
        logic [L-1:0] a2;
    } wr_t;

    typedef struct {
        int stg;
        int k;
        int rd1;
        int rd2;
        int tw;
        int bank;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    out_t last;
    out_t trace [0:TOTAL];
    bit   capture = 1'b0;

    // Model state: position inside the current transform, or -1 when idle.
    int   run_t;
    logic m_bank;
    logic m_rb;
    int   m_stage;
    wr_t  hist[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic out_t sample();
        out_t o;
        o.busy  = busy;
        o.done  = done;
        o.bank  = bank_select;
        o.rd1   = rd_address1;
        o.rd2   = rd_address2;
        o.rdv   = rd_valid;
        o.tw    = tw_addr;
        o.wr1   = wr_address1;
        o.wr2   = wr_address2;
        o.wren  = wr_en;
        o.stage = stage;
        o.rb    = result_bank;
        return o;
    endfunction

    function automatic int m_rd1(input int k, input int s);
        int span;
        span = 1 << s;
        return (k / span) * 2 * span + (k % span);
    endfunction

    function automatic int m_tw(input int k, input int s);
        int span;
        span = 1 << s;
        return (k % span) * (N / 2) / span;
    endfunction

    task automatic model_reset();
        run_t   = -1;
        m_bank  = 1'b0;
        m_rb    = 1'b0;
        m_stage = 0;
        hist.delete();
        for (int i = 0; i < PIPE_LAT; i++) hist.push_back('0);
    endtask

    task automatic model_step(input logic st, output out_t e);
        wr_t iss;
        wr_t w;
        int  s;
        int  o;
        e   = '0;
        iss = '0;
        if (run_t < 0) begin
            if (st) run_t = 0;
        end else if (run_t < TOTAL) begin
            run_t++;
        end else begin
            run_t = -1;
        end
        if (run_t >= 0 && run_t < TOTAL) begin
            s       = run_t / STAGE_LEN;
            o       = run_t % STAGE_LEN;
            m_stage = s;
            m_bank  = ((s % 2) == 1);
            e.busy  = 1'b1;
            if (o < N / 2) begin
                iss.v  = 1'b1;
                iss.a1 = L'(m_rd1(o, s));
                iss.a2 = L'(m_rd1(o, s) + (1 << s));
                e.tw   = (L-1)'(m_tw(o, s));
            end
        end else if (run_t == TOTAL) begin
            e.done = 1'b1;
            m_bank = ((L % 2) == 1);
            m_rb   = (((L - 1) % 2) == 1);
        end
        w = hist.pop_front();
        hist.push_back(iss);
        e.bank  = m_bank;
        e.rd1   = iss.a1;
        e.rd2   = iss.a2;
        e.rdv   = iss.v;
        e.wr1   = w.a1;
        e.wr2   = w.a2;
        e.wren  = w.v;
        e.stage = L'(m_stage);
        e.rb    = m_rb;
    endtask

    task automatic cycle(input logic st, input string tag);
        out_t e;
        start = st;
        @(posedge clk);
        #1;
        model_step(st, e);
        last = sample();
        check($sformatf("%s t=%0d", tag, run_t), last, e);
        if (capture && run_t >= 0 && run_t <= TOTAL) trace[run_t] = last;
    endtask

    // Asserts reset between edges so its asynchronous effect is observable at once.
    task automatic async_reset(input string tag);
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check({tag, "_immediate"}, sample(), '0);
        @(posedge clk);
        #1 rst = 1'b0;
        check({tag, "_held"}, sample(), '0);
    endtask

    vec_t vecs [8];
    int   busy_cnt, done_cnt, wr_cnt, toggles, rd_cnt, done_at, idx;

    initial begin
        vecs[0] = '{0,  0,  0,  1,  0, 0};
        vecs[1] = '{0,  5, 10, 11,  0, 0};
        vecs[2] = '{0, 15, 30, 31,  0, 0};
        vecs[3] = '{1,  3,  5,  7,  8, 1};
        vecs[4] = '{2,  5,  9, 13,  4, 0};
        vecs[5] = '{3, 12, 20, 28,  8, 1};
        vecs[6] = '{4,  5,  5, 21,  5, 0};
        vecs[7] = '{4, 15, 15, 31, 15, 0};

        rst   = 1'b0;
        start = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        #1;
        check("reset", sample(), '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_release", sample(), '0);

        for (int i = 0; i < 10; i++) cycle(1'b0, "idle");

        // Single start pulse; stray starts while busy and during done.
        capture = 1'b1;
        cycle(1'b1, "run1");
        for (int i = 0; i < TOTAL + 5; i++) cycle((i == 37) || (i == TOTAL), "run1");
        capture = 1'b0;

        busy_cnt = 0; done_cnt = 0; wr_cnt = 0; toggles = 0; rd_cnt = 0; done_at = -1;
        for (int t = 0; t <= TOTAL; t++) begin
            busy_cnt += int'(trace[t].busy);
            done_cnt += int'(trace[t].done);
            wr_cnt   += int'(trace[t].wren);
            if (trace[t].done) done_at = t;
            if (t > 0 && trace[t].bank != trace[t-1].bank) toggles++;
        end
        for (int t = 0; t < STAGE_LEN; t++) rd_cnt += int'(trace[t].rdv);
        check("busy_cycles", busy_cnt, 100);
        check("done_cycles", done_cnt, 1);
        check("done_position", done_at, 100);
        check("wr_en_cycles", wr_cnt, 80);
        check("bank_toggles", toggles, 5);
        check("final_bank", trace[TOTAL].bank, 1);
        check("result_bank", trace[TOTAL].rb, 0);
        check("stage0_reads", rd_cnt, 16);
        check("drain_first_busy", {trace[N/2].busy, trace[N/2].rdv}, 2'b10);
        check("first_wr_late", trace[PIPE_LAT-1].wren, 0);
        check("first_wr", {trace[PIPE_LAT].wren, trace[PIPE_LAT].wr1, trace[PIPE_LAT].wr2},
              {1'b1, 5'd0, 5'd1});
        check("last_wr_in_drain", {trace[STAGE_LEN-2].wren, trace[STAGE_LEN-1].wren}, 2'b10);

        foreach (vecs[i]) begin
            idx = vecs[i].stg * STAGE_LEN + vecs[i].k;
            check($sformatf("vec%0d_rd", i), {trace[idx].rdv, trace[idx].rd1, trace[idx].rd2},
                  {1'b1, 5'(vecs[i].rd1), 5'(vecs[i].rd2)});
            check($sformatf("vec%0d_tw_bank", i), {trace[idx].tw, trace[idx].bank},
                  {4'(vecs[i].tw), 1'(vecs[i].bank)});
        end

        // Start held high: done pulses once, idle samples start, next run follows.
        for (int i = 0; i < TOTAL + 3; i++) begin
            cycle(1'b1, "held");
            if (i == TOTAL)     check("held_done", {last.done, last.busy}, 2'b10);
            if (i == TOTAL + 1) check("held_idle", {last.done, last.busy}, 2'b00);
            if (i == TOTAL + 2) check("held_restart", {last.busy, last.rdv, last.stage, last.rd1},
                                      {1'b1, 1'b1, 5'd0, 5'd0});
        end

        // Abort in stage 2 mid-READ, then a clean full run.
        for (int i = 0; i < 2 * STAGE_LEN + 7; i++) cycle(1'b0, "to_abort");
        check("abort_point", {last.stage, last.rdv}, {5'd2, 1'b1});
        async_reset("abort");
        cycle(1'b0, "post_abort");
        busy_cnt = 0;
        done_cnt = 0;
        cycle(1'b1, "rerun");
        check("rerun_first", {last.stage, last.rd1, last.rd2}, {5'd0, 5'd0, 5'd1});
        busy_cnt += int'(last.busy);
        for (int i = 0; i < TOTAL + 2; i++) begin
            cycle(1'b0, "rerun");
            busy_cnt += int'(last.busy);
            done_cnt += int'(last.done);
        end
        check("rerun_busy_cycles", busy_cnt, 100);
        check("rerun_done_cycles", done_cnt, 1);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 399) == 0) async_reset("rand_reset");
            else cycle($urandom_range(0, 7) == 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Drives the ping-pong FFT working memory through all log2(N) radix-2 stages.
- Per stage it:
  - issues butterfly read-address pairs and twiddle indices;
  - delays those addresses through the butterfly pipeline to produce write-address pairs and wr_en;
  - flips bank_select between stages.
- It is the initiator facing the two-bank RAM interface: it generates bank_select, wr_en, rd_address1/2 and wr_address1/2. The butterfly datapath sits between samp1/2 and comp1/2.

Parameters:
- N, 32, FFT size, power of two, >= 4.
- PIPE_LAT, 3, cycles from read address issued to matching result presented on comp1/2 (RAM read plus butterfly), >= 1.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begin a transform; sampled only in IDLE.
- busy  out  1  high in READ, DRAIN, SWAP.
- done  out  1  one-cycle pulse when the transform completes.
- bank_select  out  1  0 = write bank0 / read bank1; 1 = write bank1 / read bank0.
- rd_address1  out  log2(N)  butterfly top-input read index.
- rd_address2  out  log2(N)  butterfly bottom-input read index.
- rd_valid  out  1  read addresses meaningful this cycle.
- tw_addr  out  log2(N)-1  twiddle ROM index, aligned with rd_address.
- wr_address1  out  log2(N)  write index for comp1.
- wr_address2  out  log2(N)  write index for comp2.
- wr_en  out  1  write comp1/comp2 this cycle.
- stage  out  log2(N)  current stage 0..log2(N)-1.
- result_bank  out  1  bank holding final spectrum, valid from done onward.

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE;
  - butterfly counter k = 0;
  - write delay line cleared (all valid bits 0).
- Input data convention: input data resides in bank1 at start, so stage s writes bank (s mod 2).
- States:
  - IDLE: start=1 at an edge -> READ; stage=0; k=0; bank_select=0.
  - READ: N/2 cycles.
    - rd_valid=1.
    - k increments 0..N/2-1.
    - At k=N/2-1 -> DRAIN.
  - DRAIN: exactly PIPE_LAT cycles, rd_valid=0; then -> SWAP.
  - SWAP: 1 cycle.
    - bank_select toggles.
    - If stage=log2(N)-1 -> DONE; else stage++, k=0, -> READ.
  - DONE: 1 cycle, done=1, busy=0; -> IDLE.
- Address generation for stage s, with span=2^s, pos=k mod span, group=k>>s:
  - rd_address1 = group*2*span + pos;
  - rd_address2 = rd_address1 + span;
  - tw_addr = pos << (log2(N)-1-s), truncated to log2(N)-1 bits.
- Outputs when rd_valid=0: rd_address and tw_addr hold 0.
- Write path:
  - rd_address1/2 and rd_valid pass through a PIPE_LAT-deep register delay line.
  - wr_address1/2 and wr_en equal the values issued PIPE_LAT cycles earlier.
  - Write goes to the same indices in the opposite bank (in-place ping-pong).
- Stage timing:
  - The last write of a stage lands in the last DRAIN cycle.
  - wr_en is never high in SWAP, DONE or IDLE.
  - Reads and writes of different stages never overlap.
- Stage length: N/2 + PIPE_LAT + 1 cycles.
- Total run: log2(N)*(N/2+PIPE_LAT+1) busy cycles, then the done cycle.
- End of transform:
  - result_bank = (log2(N)-1) mod 2, registered at the final SWAP.
  - After done, bank_select = log2(N) mod 2, i.e. the read side points at result_bank.
- Boundary conditions:
  - start while busy or in DONE: ignored.
  - start held high continuously: a new transform begins on the cycle after DONE (IDLE sees start).
  - reset mid-operation: immediate return to IDLE, delay line flushed, wr_en=0 in the same cycle reset asserts.
  - k and stage counters never wrap past their terminal values.

Test Plan:
1. Reset, then idle with start=0 for 10 cycles:
   - busy=0, done=0, wr_en=0, bank_select=0 throughout.
2. N=32, PIPE_LAT=3, pulse start; check stage 0:
   - k=0 -> rd (0,1), tw 0.
   - k=5 -> rd (10,11), tw 0.
   - wr_en first high 3 cycles after first rd_valid, with wr (0,1).
   - 16 reads then 3 drain cycles.
3. Same run, stage 2, k=5:
   - rd (9,13), tw 4, bank_select=0.
   - Stage 4, k=5: rd (5,21), tw 5.
4. Full-run count for N=32:
   - busy high exactly 100 cycles, then done high 1 cycle.
   - bank_select toggles 5 times, ending at 1.
   - result_bank=0.
   - Exactly 80 wr_en cycles total.
5. Assert reset in stage 2 mid-READ:
   - wr_en=0 immediately, busy=0, state IDLE.
   - Next start runs the full 100-cycle sequence from stage 0.
6. Assert start during busy and again during done:
   - No effect on counters or timing; done pulses once.
   - With start held high, a new stage 0 READ begins 1 cycle after done.
